// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM states and frame-length helper for uart_core
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    // Frame length in bit periods: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable down-counter marking the end of a bit period
// Ports: clk_i/rst_i clock and sync active-high reset; load_i/load_val_i reload;
//        en_i counts down; expire_o high while enabled at zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int W            = $clog2(CLKS_PER_BIT)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // The owning FSM reloads in the same cycle it sees expire_o, so a value of
    // N gives an expiry N+1 cycles after the load.
    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - parametrised full-duplex UART with valid/ready word interfaces
// Ports: clk/rst clock and sync active-high reset; uart_rx/uart_tx serial pins;
//        tx_data/tx_valid/tx_ready transmit word; rx_data/rx_valid/rx_ready receive
//        word with rx_parity_err/rx_frame_err; rx_overrun sticky, cleared by err_clr.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 err_clr
);

    localparam int             TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  FULL_BIT  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  HALF_BIT  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_load, tx_expire;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tx_load),
        .load_val_i (FULL_BIT),
        .en_i       (tx_state_q != S_IDLE),
        .expire_o   (tx_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_cnt_q   <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // The line is registered: each transition drives the value of the bit
    // being entered, so the pin changes exactly on bit boundaries.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_cnt_d   = tx_cnt_q;
        tx_line_d  = tx_line_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_line_d = 1'b1;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = (PARITY == PAR_ODD) ? ~(^tx_data) : (^tx_data);
                    tx_line_d  = 1'b0;
                    tx_load    = 1'b1;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_expire) begin
                    tx_line_d  = tx_shift_q[0];
                    tx_cnt_d   = '0;
                    tx_load    = 1'b1;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_expire) begin
                    tx_load = 1'b1;
                    if (tx_cnt_q == LAST_DATA) begin
                        tx_cnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            tx_line_d  = tx_par_q;
                            tx_state_d = S_PARITY;
                        end else begin
                            tx_line_d  = 1'b1;
                            tx_state_d = S_STOP;
                        end
                    end else begin
                        tx_cnt_d   = tx_cnt_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_expire) begin
                    tx_line_d  = 1'b1;
                    tx_cnt_d   = '0;
                    tx_load    = 1'b1;
                    tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_expire) begin
                    tx_line_d = 1'b1;
                    if (tx_cnt_q == LAST_STOP) begin
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                        tx_load  = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    assign uart_tx  = tx_line_q;
    assign tx_ready = (tx_state_q == S_IDLE) && !rst;

    // ---------------- receiver ----------------
    logic [1:0]           sync_q;
    logic                 rx_s;
    uart_state_e          rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_armed_q, rx_armed_d;
    logic                 rx_load, rx_expire, rx_done;
    logic [TW-1:0]        rx_load_val;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_perr_out_q, rx_ferr_out_q, rx_ovr_q;

    assign rx_s = sync_q[1];

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (rx_load),
        .load_val_i (rx_load_val),
        .en_i       (rx_state_q != S_IDLE),
        .expire_o   (rx_expire)
    );

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        rx_perr_d   = rx_perr_q;
        rx_ferr_d   = rx_ferr_q;
        rx_armed_d  = rx_armed_q;
        rx_load     = 1'b0;
        rx_load_val = FULL_BIT;
        rx_done     = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                // After a frame ending on a low stop bit (e.g. a break) the
                // line must be seen high before a new start is accepted.
                if (!rx_armed_q) begin
                    rx_armed_d = rx_s;
                end else if (!rx_s) begin
                    rx_load     = 1'b1;
                    rx_load_val = HALF_BIT;
                    rx_state_d  = S_START;
                end
            end
            S_START: begin
                if (rx_expire) begin
                    if (rx_s) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_load    = 1'b1;
                        rx_cnt_d   = '0;
                        rx_perr_d  = 1'b0;
                        rx_ferr_d  = 1'b0;
                        rx_state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_expire) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_load    = 1'b1;
                    if (rx_cnt_q == LAST_DATA) begin
                        rx_cnt_d   = '0;
                        rx_state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_expire) begin
                    rx_perr_d  = rx_s ^ ((PARITY == PAR_ODD) ? ~(^rx_shift_q) : (^rx_shift_q));
                    rx_load    = 1'b1;
                    rx_cnt_d   = '0;
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_expire) begin
                    rx_ferr_d = rx_ferr_q | ~rx_s;
                    if (rx_cnt_q == LAST_STOP) begin
                        rx_done    = 1'b1;
                        rx_armed_d = rx_s;
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                        rx_load  = 1'b1;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= 2'b11;
            rx_state_q    <= S_IDLE;
            rx_shift_q    <= '0;
            rx_cnt_q      <= '0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_armed_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_out_q <= 1'b0;
            rx_ferr_out_q <= 1'b0;
            rx_ovr_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_armed_q <= rx_armed_d;

            // A word being consumed this cycle frees the holding register.
            if (rx_done && (!rx_valid_q || rx_ready)) begin
                rx_valid_q    <= 1'b1;
                rx_data_q     <= rx_shift_q;
                rx_perr_out_q <= rx_perr_q;
                rx_ferr_out_q <= rx_ferr_d;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (rx_done && rx_valid_q && !rx_ready) begin
                rx_ovr_q <= 1'b1;
            end else if (err_clr) begin
                rx_ovr_q <= 1'b0;
            end
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = (PARITY != PAR_NONE) && rx_perr_out_q;
    assign rx_frame_err  = rx_ferr_out_q;
    assign rx_overrun    = rx_ovr_q;

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART: the successor to the fixed 8N1 uart block.
- Configurable data width, parity mode, stop-bit count and bit period.
- Valid/ready byte interfaces on both the TX and RX sides, plus per-word error status and a sticky overrun flag.
- Sits between the board pins (uart_rx/uart_tx) and the mu0 memory-mapped I/O or debug logic.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per bit period; legal range 4..65535.
- DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial input, asynchronous to clk; idle high.
- uart_tx  out  1  serial output; idle high.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a word.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  rx_data, rx_parity_err and rx_frame_err are valid.
- rx_ready  in  1  consumer accepts rx_data.
- rx_parity_err  out  1  parity mismatch on the held word; always 0 when PARITY = 0.
- rx_frame_err  out  1  a stop bit was sampled low on the held word.
- rx_overrun  out  1  sticky: a frame completed while rx_valid was high.
- err_clr  in  1  clears rx_overrun.

Behaviour:
- Reset values: uart_tx = 1, tx_ready = 0 during reset and 1 in the first cycle after, rx_valid = 0, rx_data = 0, all error flags = 0, both FSMs in IDLE.
- Reset mid-frame: both frames are abandoned immediately and uart_tx returns high the cycle after rst is sampled.
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1). Frame length F = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.
- Bit timer: a down-counter reloaded to CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.

TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY = 0) -> STOP -> IDLE.
- tx_ready = 1 only in IDLE.
- Handshake: tx_valid & tx_ready at edge n captures tx_data into a shift register. uart_tx goes low from cycle n+1, tx_ready drops at n+1, and each bit holds CLKS_PER_BIT cycles.
- tx_ready returns high exactly F*CLKS_PER_BIT cycles after n+1, so back-to-back words have no idle gap.
- Parity bit: even mode sends the XOR of the data bits; odd mode sends its inverse.
- tx_data changes after capture have no effect on the frame in flight.

RX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY = 0) -> STOP -> IDLE.
- Input synchronisation: uart_rx passes through a 2-flop synchroniser, rx_s. All RX latency below is quoted from rx_s.
- IDLE: rx_s = 0 enters START with the counter at CLKS_PER_BIT/2 - 1 (mid-bit alignment).
- START: at expiry, if rx_s = 1 the start is false and the FSM returns to IDLE with no output. Otherwise it moves to DATA.
- DATA, PARITY and STOP each sample once, at mid-bit (after a full CLKS_PER_BIT).
- STOP: every stop bit is checked; any low stop bit sets the frame error for that word. After the last stop-bit sample the FSM returns to IDLE immediately, without waiting out the half bit, so that closely spaced frames are accepted.
- Word completion, when rx_valid = 0 in the same cycle: on the cycle after the last stop-bit sample, rx_valid = 1 and rx_data, rx_parity_err and rx_frame_err are loaded.
- Word completion, when rx_valid = 1 (unconsumed): the new word is dropped, the held word and its flags are unchanged, and rx_overrun is set.
- If rx_valid & rx_ready occurs in the same cycle as completion, the word is accepted, not counted as overrun.
- rx_valid drops the cycle after rx_valid & rx_ready. rx_data is held until the next load.
- rx_overrun clears only on err_clr or rst. If err_clr and a new overrun occur in the same cycle, the set wins.
- A line held low (break) produces one word with rx_frame_err = 1 and data 0. The FSM then stays in IDLE until rx_s has been sampled high once before re-arming.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2;
  - the FSM state encodings (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP);
  - a function computing F from the parameters.
- One natural sub-module: uart_bit_timer (load/enable/expire counter, width $clog2(CLKS_PER_BIT)), instantiated once in the TX path and once in the RX path.
- The TX and RX FSMs stay in uart_core.

Test Plan:
1. Defaults (8N1, CLKS_PER_BIT = 8): send 0x5A with a single tx_valid pulse. uart_tx carries 0, 0,1,0,1,1,0,1,0, 1, each bit 8 cycles; tx_ready returns high 80 cycles after the first low cycle.
2. Loopback (uart_tx wired to uart_rx), PARITY = 1, STOP_BITS = 2: send 0xA5, 0xFF, 0x00 back-to-back with rx_ready = 1. Each word appears on rx_data with rx_valid high for 1 cycle; rx_parity_err = 0 and rx_frame_err = 0 for all three.
3. PARITY = 2: drive an 8O1 frame for 0x03 with the parity bit forced to 0 (correct value is 1). rx_data = 0x03, rx_valid = 1, rx_parity_err = 1.
4. Drive 0x41 with the stop bit low, then a 3-cycle low glitch on idle. Result: exactly one word, 0x41 with rx_frame_err = 1; no word from the glitch (false start).
5. Hold rx_ready = 0 and receive 0x11 then 0x22. rx_data stays 0x11 and rx_overrun = 1. Pulse err_clr: rx_overrun = 0 and rx_valid is still 1.
6. Assert rst for 1 cycle mid-TX frame and mid-RX data bit 3. Next cycle: uart_tx = 1 and rx_valid = 0. A fresh 0x5A frame then completes normally in both directions.
